m_stage: RTL and testbench
==========================

M_STAGE -- requirements
Module: M_stage

Interface
REQ-001 Parameters: none; N_BITS = 32 from core_types_pkg.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 vld_in  in  1  X-stage result valid; X has already applied squash.
REQ-005 data_in  in  N_BITS  X result: effective address for load/store, writeback value otherwise.
REQ-006 store_data_in  in  N_BITS  rs2 value for stores.
REQ-007 mem_ctrl_in  in  5  {is_load, is_store, is_unsigned, size[1:0]}; size 00 byte, 01 half, 10 word, 11 treated as word.
REQ-008 rf_ctrl_pkt_in / rf_ctrl_pkt_out  in/out  $bits(rf_ctrl_t)  regfile control, registered pass-through.
REQ-009 data_out  out  N_BITS  writeback value to W.
REQ-010 vld  out  1  M result valid this cycle.
REQ-011 misalign_err  out  1  qualifies vld: access dropped as misaligned.
REQ-012 stall_in  in  1  stall from W; stall  out  1  stall to X (stall_in OR gen_stall).
REQ-013 dmem_req_vld/dmem_req_rdy  out/in  1  request handshake, transfer when both high.
REQ-014 dmem_we  out  1; dmem_addr  out  N_BITS; dmem_wdata  out  N_BITS; dmem_wstrb  out  4.
REQ-015 dmem_resp_vld  in  1; dmem_rdata  in  N_BITS  load response, one per accepted load.

Function
REQ-016 Pipeline registers (vld, data, store data, mem ctrl, rf ctrl) SHALL capture when !stall, hold otherwise.
REQ-017 FSM states IDLE, REQ, WAIT_RESP, DONE; is_mem = vld_raw AND (is_load OR is_store).
REQ-018 IDLE with is_mem: dmem_req_vld=1; accepted store -> DONE; accepted load -> WAIT_RESP; not accepted -> REQ.
REQ-019 REQ: dmem_req_vld held with addr/we/wdata/wstrb stable until dmem_req_rdy; then as REQ-018.
REQ-020 WAIT_RESP: on dmem_resp_vld capture extended load data into hold register, -> DONE.
REQ-021 DONE: when !stall_in stage advances, -> IDLE same edge as new capture; stays DONE while stall_in.
REQ-022 gen_stall = is_mem AND state != DONE; vld = vld_raw AND !gen_stall.
REQ-023 Minimum latency: non-mem 0 extra cycles; store 1 extra (req accepted in IDLE, vld next cycle); load 2 extra with rdy and resp on first opportunity.
REQ-024 Load extension: lane from addr[1:0] (byte) or addr[1] (half); zero-extend if is_unsigned else sign-extend.
REQ-025 Store: wdata = byte replicated x4, half replicated x2, or word; wstrb = 0001<<addr[1:0], 0011<<{addr[1],0}, or 1111.
REQ-026 dmem_addr = data_in; dmem_we = is_store; data_out = load data when is_load else data_in.
REQ-027 stall_in while request or response outstanding SHALL NOT cancel or repeat the access.
REQ-028 dmem_resp_vld outside WAIT_RESP SHALL be ignored; at most one request outstanding.

Reset
REQ-029 rst SHALL set state IDLE and clear all pipeline and hold registers; vld, dmem_req_vld, misalign_err, stall-generated term all 0 in the cycle after rst.
REQ-030 rst mid-access SHALL abandon it; a later stale dmem_resp_vld is dropped per REQ-028.

Configuration
REQ-031 Macro M_STAGE_MISALIGN_CHK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 issues no request, FSM goes directly to DONE, vld=1 with misalign_err=1, rf_ctrl_pkt_out unchanged.
REQ-032 Macro undefined: addr low bits forced aligned (half clears bit 0, word clears [1:0]) for addr, strobe and lane; misalign_err tied 0.

Verification
REQ-033 Word load addr 0x100, rdy=1, resp next cycle rdata=0xDEADBEEF -> vld 2 cycles after capture, data_out=0xDEADBEEF, stall high 2 cycles.
REQ-034 Signed byte load addr 0x103, rdata=0x80FFFFFF -> data_out=0xFFFFFF80; unsigned -> 0x00000080.
REQ-035 Half store addr 0x102 data 0x1234ABCD, rdy low 3 cycles -> req held 4 cycles stable, wdata=0xABCDABCD, wstrb=1100, vld next cycle.
REQ-036 Load in WAIT_RESP with stall_in=1 for 5 cycles -> single request, data held in DONE, vld continuous, advances when stall_in=0.
REQ-037 Word load addr 0x101: with macro -> no dmem_req_vld, vld=1, misalign_err=1; without -> dmem_addr=0x100.
REQ-038 rst asserted in WAIT_RESP, resp arrives after release -> state IDLE, vld=0, response ignored.

Source files
------------

// File: rtl/m_stage.sv
// Memory stage: registers the X-stage result, runs the data-memory handshake for loads/stores
// and formats store lanes / load extension. Define M_STAGE_MISALIGN_CHK_EN to trap misaligned accesses.
package core_types_pkg;
  localparam int N_BITS = 32;
  typedef struct packed {
    logic       wr_en;
    logic [4:0] rd_addr;
  } rf_ctrl_t;
endpackage

module m_stage
  import core_types_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          vld_in,
  input  logic [N_BITS-1:0]             data_in,
  input  logic [N_BITS-1:0]             store_data_in,
  input  logic [4:0]                    mem_ctrl_in,
  input  logic [$bits(rf_ctrl_t)-1:0]   rf_ctrl_pkt_in,
  output logic [$bits(rf_ctrl_t)-1:0]   rf_ctrl_pkt_out,
  output logic [N_BITS-1:0]             data_out,
  output logic                          vld,
  output logic                          misalign_err,
  input  logic                          stall_in,
  output logic                          stall,
  output logic                          dmem_req_vld,
  input  logic                          dmem_req_rdy,
  output logic                          dmem_we,
  output logic [N_BITS-1:0]             dmem_addr,
  output logic [N_BITS-1:0]             dmem_wdata,
  output logic [3:0]                    dmem_wstrb,
  input  logic                          dmem_resp_vld,
  input  logic [N_BITS-1:0]             dmem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} state_t;

  state_t                        state_q, state_d;
  logic                          vld_raw;
  logic [N_BITS-1:0]             data_q, sdata_q, load_q, load_ext, addr_eff;
  logic [4:0]                    mctl_q;
  logic [$bits(rf_ctrl_t)-1:0]   rf_q;
  logic                          is_load, is_store, is_uns, is_mem, is_half, is_word;
  logic [1:0]                    size;
  logic                          gen_stall, mis_drop, load_en;
  logic [7:0]                    lane_b;
  logic [15:0]                   lane_h;

  assign {is_load, is_store, is_uns, size} = mctl_q;
  assign is_mem  = vld_raw & (is_load | is_store);
  assign is_half = (size == 2'b01);
  assign is_word = size[1];

`ifdef M_STAGE_MISALIGN_CHK_EN
  assign mis_drop = (is_half & data_q[0]) | (is_word & (data_q[1:0] != 2'b00));
`else
  assign mis_drop = 1'b0;
`endif

  // Aligned address feeds the bus, the strobes and the load lane select alike.
  always_comb begin
    addr_eff = data_q;
    if (is_half)      addr_eff[0]   = 1'b0;
    else if (is_word) addr_eff[1:0] = 2'b00;
  end

  always_comb begin
    dmem_wdata = sdata_q;
    dmem_wstrb = 4'b1111;
    case (size)
      2'b00: begin
        dmem_wdata = {4{sdata_q[7:0]}};
        dmem_wstrb = 4'b0001 << addr_eff[1:0];
      end
      2'b01: begin
        dmem_wdata = {2{sdata_q[15:0]}};
        dmem_wstrb = 4'b0011 << {addr_eff[1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (addr_eff[1:0])
      2'd0:    lane_b = dmem_rdata[7:0];
      2'd1:    lane_b = dmem_rdata[15:8];
      2'd2:    lane_b = dmem_rdata[23:16];
      default: lane_b = dmem_rdata[31:24];
    endcase
    lane_h = addr_eff[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (size)
      2'b00:   load_ext = {{24{~is_uns & lane_b[7]}}, lane_b};
      2'b01:   load_ext = {{16{~is_uns & lane_h[15]}}, lane_h};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    dmem_req_vld = 1'b0;
    load_en      = 1'b0;
    gen_stall    = is_mem & (state_q != DONE);
    case (state_q)
      IDLE: begin
        if (is_mem) begin
          if (mis_drop) begin
            state_d = DONE;
          end else begin
            dmem_req_vld = 1'b1;
            if (dmem_req_rdy) state_d = is_load ? WAIT_RESP : DONE;
            else              state_d = REQ;
          end
        end
      end
      REQ: begin
        dmem_req_vld = 1'b1;
        if (dmem_req_rdy) state_d = is_load ? WAIT_RESP : DONE;
      end
      WAIT_RESP: begin
        if (dmem_resp_vld) begin
          load_en = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!stall_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall = stall_in | gen_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vld_raw <= 1'b0;
      data_q  <= '0;
      sdata_q <= '0;
      mctl_q  <= '0;
      rf_q    <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      if (!stall) begin
        vld_raw <= vld_in;
        data_q  <= data_in;
        sdata_q <= store_data_in;
        mctl_q  <= mem_ctrl_in;
        rf_q    <= rf_ctrl_pkt_in;
      end
      if (load_en) load_q <= load_ext;
    end
  end

  assign vld             = vld_raw & ~gen_stall;
  assign misalign_err    = vld & mis_drop;
  assign data_out        = is_load ? load_q : data_q;
  assign dmem_addr       = addr_eff;
  assign dmem_we         = is_store;
  assign rf_ctrl_pkt_out = rf_q;

endmodule

// File: tb/tb_m_stage.sv
// Self-checking bench for m_stage: randomized traffic against a byte-level memory model with a
// request/result scoreboard, followed by directed latency, extension, misalignment and reset cases.
module tb_m_stage;
  localparam int RFW = $bits(core_types_pkg::rf_ctrl_t);

`ifdef M_STAGE_MISALIGN_CHK_EN
  localparam bit MIS_CHK = 1'b1;
`else
  localparam bit MIS_CHK = 1'b0;
`endif

  logic            clk = 1'b0, rst = 1'b1;
  logic            vld_in = 1'b0, stall_in = 1'b0;
  logic [31:0]     data_in = '0, store_data_in = '0;
  logic [4:0]      mem_ctrl_in = '0;
  logic [RFW-1:0]  rf_ctrl_pkt_in = '0, rf_ctrl_pkt_out;
  logic [31:0]     data_out, dmem_addr, dmem_wdata;
  logic            vld, misalign_err, stall, dmem_req_vld, dmem_we;
  logic            dmem_req_rdy = 1'b0, dmem_resp_vld = 1'b0;
  logic [31:0]     dmem_rdata = '0;
  logic [3:0]      dmem_wstrb;

  always #5 clk = ~clk;

  m_stage dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .data_in(data_in), .store_data_in(store_data_in),
    .mem_ctrl_in(mem_ctrl_in), .rf_ctrl_pkt_in(rf_ctrl_pkt_in), .rf_ctrl_pkt_out(rf_ctrl_pkt_out),
    .data_out(data_out), .vld(vld), .misalign_err(misalign_err), .stall_in(stall_in), .stall(stall),
    .dmem_req_vld(dmem_req_vld), .dmem_req_rdy(dmem_req_rdy), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_resp_vld(dmem_resp_vld), .dmem_rdata(dmem_rdata)
  );

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {logic [31:0] data; logic chk_data; logic mis; logic [RFW-1:0] rf;} out_t;
  typedef struct {logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] wstrb;} req_t;
  out_t out_q[$];
  req_t req_q[$];

  // Reference memory (bytes at 0x100..0x11F) and the responder's own word memory.
  logic [7:0]  ref_mem [0:31];
  logic [31:0] dut_mem [0:7];
  logic        rand_on = 1'b0, resp_pending = 1'b0, req_wait = 1'b0;
  int          resp_dly = 0;
  logic [2:0]  resp_idx = '0;

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  task automatic model_accept(input logic [31:0] d, input logic [31:0] sd, input logic [4:0] ctl,
                              input logic [RFW-1:0] rf);
    out_t o; req_t r; int n, off; logic [31:0] ea, v;
    o.data = d; o.chk_data = 1'b1; o.mis = 1'b0; o.rf = rf;
    if (ctl[4] || ctl[3]) begin
      n = nbytes(ctl[1:0]);
      if (MIS_CHK && (d % n) != 0) begin
        o.mis = 1'b1;
        o.chk_data = 1'b0;
      end else begin
        ea = d - (d % n);
        off = int'(ea % 4);
        r.addr = ea; r.we = ctl[3]; r.wdata = '0; r.wstrb = '0;
        if (ctl[3]) begin
          for (int j = 0; j < 4; j++) r.wdata[8*j +: 8] = sd[8*(j % n) +: 8];
          for (int i = 0; i < n; i++) begin
            r.wstrb[off+i] = 1'b1;
            ref_mem[ea - 32'h100 + i] = sd[8*i +: 8];
          end
        end else begin
          v = '0;
          for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[ea - 32'h100 + i];
          if (!ctl[2] && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
          o.data = v;
        end
        req_q.push_back(r);
      end
    end
    out_q.push_back(o);
  endtask

  // Memory responder: random ready, random response delay, stray responses when idle.
  initial forever begin
    req_t r;
    @(negedge clk);
    if (rand_on) begin
      dmem_req_rdy  = ($urandom_range(0, 2) != 0);
      dmem_resp_vld = 1'b0;
      if (resp_pending) begin
        if (resp_dly == 0) begin
          dmem_resp_vld = 1'b1;
          dmem_rdata    = dut_mem[resp_idx];
          resp_pending  = 1'b0;
        end else resp_dly--;
      end else if ($urandom_range(0, 7) == 0) begin
        dmem_resp_vld = 1'b1;
        dmem_rdata    = $urandom;
      end
      #1;
      if (req_wait) check("req_held", {31'd0, dmem_req_vld}, 32'd1);
      req_wait = 1'b0;
      if (dmem_req_vld) begin
        if (req_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL req_unexpected: request addr 0x%08h, expected none", dmem_addr);
        end else begin
          r = req_q[0];
          check("req_addr", dmem_addr, r.addr);
          check("req_we", {31'd0, dmem_we}, {31'd0, r.we});
          if (r.we) begin
            check("req_wdata", dmem_wdata, r.wdata);
            check("req_wstrb", {28'd0, dmem_wstrb}, {28'd0, r.wstrb});
          end
          if (dmem_req_rdy) begin
            void'(req_q.pop_front());
            if (dmem_we) begin
              for (int j = 0; j < 4; j++)
                if (dmem_wstrb[j]) dut_mem[dmem_addr[4:2]][8*j +: 8] = dmem_wdata[8*j +: 8];
            end else begin
              resp_pending = 1'b1;
              resp_dly     = $urandom_range(0, 2);
              resp_idx     = dmem_addr[4:2];
            end
          end else req_wait = 1'b1;
        end
      end
    end
  end

  // Result monitor: a result retires in any cycle with vld high and no downstream stall.
  initial forever begin
    out_t o;
    @(negedge clk); #2;
    if (rand_on && vld && !stall_in) begin
      if (out_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL out_unexpected: data_out 0x%08h, expected no result", data_out);
      end else begin
        o = out_q.pop_front();
        if (o.chk_data) check("out_data", data_out, o.data);
        check("out_misalign", {31'd0, misalign_err}, {31'd0, o.mis});
        check("out_rf", 32'(rf_ctrl_pkt_out), 32'(o.rf));
      end
    end
  end

  task automatic gen_txn();
    int kind;
    kind           = $urandom_range(0, 2);
    vld_in         = ($urandom_range(0, 9) != 0);
    store_data_in  = $urandom;
    rf_ctrl_pkt_in = RFW'($urandom);
    if (kind == 0) begin
      data_in     = $urandom;
      mem_ctrl_in = {2'b00, 3'($urandom)};
    end else begin
      data_in     = 32'h100 + $urandom_range(0, 31);
      mem_ctrl_in = {(kind == 1), (kind == 2), 1'($urandom), 2'($urandom)};
    end
  endtask

  // Directed op with an always-ready memory answering one cycle after acceptance.
  // lat = cycles after capture before vld; req_addr/wdata/wstrb record the last accepted request.
  task automatic run_op(input logic [31:0] a, input logic [31:0] sd, input logic [4:0] ctl,
                        input logic [31:0] rd, output int lat, output int nreq,
                        output logic [31:0] dout, output logic mis, output logic [31:0] req_addr,
                        output logic [31:0] req_wdata, output logic [3:0] req_wstrb);
    logic resp_next;
    @(negedge clk);
    vld_in = 1'b1; data_in = a; store_data_in = sd; mem_ctrl_in = ctl;
    stall_in = 1'b0; dmem_req_rdy = 1'b1; dmem_resp_vld = 1'b0;
    @(negedge clk);
    vld_in = 1'b0;
    lat = 0; nreq = 0; resp_next = 1'b0; dout = '0; mis = 1'b0;
    req_addr = 32'hFFFF_FFFF; req_wdata = '0; req_wstrb = '0;
    while (lat < 20) begin
      dmem_resp_vld = resp_next;
      dmem_rdata    = rd;
      resp_next     = 1'b0;
      #1;
      if (vld) begin
        dout = data_out;
        mis  = misalign_err;
        break;
      end
      if (dmem_req_vld && dmem_req_rdy) begin
        nreq++;
        req_addr = dmem_addr; req_wdata = dmem_wdata; req_wstrb = dmem_wstrb;
        resp_next = !dmem_we;
      end
      lat++;
      @(negedge clk);
    end
    dmem_resp_vld = 1'b0;
  endtask

  initial begin
    int acc, cyc, lat, nreq;
    logic need_new, mis;
    logic [31:0] dout, raddr, rwdata;
    logic [3:0] rwstrb;

    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, cyc, lat, nreq;
    logic need_new, mis;
    logic [31:0] dout, raddr, rwdata;
    logic [3:0] rwstrb;

    for (int k = 0; k < 32; k++) begin
      ref_mem[k] = 8'(k * 37 + 5);
      dut_mem[k/4][8*(k%4) +: 8] = 8'(k * 37 + 5);
    end

    repeat (3) @(negedge clk);
    #1;
    check("rst_vld", {31'd0, vld}, 32'd0);
    check("rst_req_vld", {31'd0, dmem_req_vld}, 32'd0);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    rand_on = 1'b1;
    acc = 0; cyc = 0; need_new = 1'b1;
    while (acc < 400 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      stall_in = ($urandom_range(0, 3) == 0);
      if (need_new) gen_txn();
      #1;
      need_new = !stall;
      if (!stall) begin
        acc++;
        if (vld_in) model_accept(data_in, store_data_in, mem_ctrl_in, rf_ctrl_pkt_in);
      end
    end
    check("rand_accepted", 32'(acc), 32'd400);

    cyc = 0;
    while (cyc < 300) begin
      @(negedge clk);
      vld_in = 1'b0; stall_in = 1'b0;
      if (out_q.size() == 0 && req_q.size() == 0 && !resp_pending) break;
      cyc++;
    end
    check("drain_results_left", 32'(out_q.size()), 32'd0);
    check("drain_requests_left", 32'(req_q.size()), 32'd0);
    rand_on = 1'b0;
    dmem_req_rdy = 1'b0; dmem_resp_vld = 1'b0;

    run_op(32'h100, 32'h0, 5'b10010, 32'hDEADBEEF, lat, nreq, dout, mis, raddr, rwdata, rwstrb);
    check("lw_latency", 32'(lat), 32'd2);
    check("lw_nreq", 32'(nreq), 32'd1);
    check("lw_data", dout, 32'hDEADBEEF);

    run_op(32'h103, 32'h0, 5'b10000, 32'h80FFFFFF, lat, nreq, dout, mis, raddr, rwdata, rwstrb);
    check("lb_data", dout, 32'hFFFFFF80);
    run_op(32'h103, 32'h0, 5'b10100, 32'h80FFFFFF, lat, nreq, dout, mis, raddr, rwdata, rwstrb);
    check("lbu_data", dout, 32'h00000080);

    run_op(32'h12345678, 32'h0, 5'b00010, 32'h0, lat, nreq, dout, mis, raddr, rwdata, rwstrb);
    check("alu_latency", 32'(lat), 32'd0);
    check("alu_data", dout, 32'h12345678);

    run_op(32'h102, 32'h1234ABCD, 5'b01001, 32'h0, lat, nreq, dout, mis, raddr, rwdata, rwstrb);
    check("sh_latency", 32'(lat), 32'd1);
    check("sh_wdata", rwdata, 32'hABCDABCD);
    check("sh_wstrb", {28'd0, rwstrb}, 32'hC);
    check("sh_data", dout, 32'h102);

    run_op(32'h101, 32'h0, 5'b10010, 32'hCAFEF00D, lat, nreq, dout, mis, raddr, rwdata, rwstrb);
    check("mis_nreq", 32'(nreq), MIS_CHK ? 32'd0 : 32'd1);
    check("mis_err", {31'd0, mis}, {31'd0, MIS_CHK});
    check("mis_addr", raddr, MIS_CHK ? 32'hFFFF_FFFF : 32'h100);

    @(negedge clk);
    vld_in = 1'b1; data_in = 32'h104; mem_ctrl_in = 5'b10010; stall_in = 1'b0; dmem_req_rdy = 1'b1;
    @(negedge clk);
    vld_in = 1'b0;
    #1 check("rstmid_req", {31'd0, dmem_req_vld}, 32'd1);
    @(negedge clk);
    #1 check("rstmid_wait_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; dmem_resp_vld = 1'b1; dmem_rdata = 32'hBAD0BAD0;
    #1;
    check("rstmid_vld", {31'd0, vld}, 32'd0);
    check("rstmid_req_vld", {31'd0, dmem_req_vld}, 32'd0);
    check("rstmid_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    dmem_resp_vld = 1'b0;
    #1 check("rstmid_vld_after_resp", {31'd0, vld}, 32'd0);

    run_op(32'h108, 32'h0, 5'b10010, 32'h600DF00D, lat, nreq, dout, mis, raddr, rwdata, rwstrb);
    check("post_rst_lw_latency", 32'(lat), 32'd2);
    check("post_rst_lw_data", dout, 32'h600DF00D);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
